dnn_result_argmax: RTL
======================

// Module: dnn_result_argmax
// PURPOSE
//  Parametrised result stage behind the DNN inference core. Captures all
//  NUM_CLASSES signed class scores when the core finishes, then scans them
//  sequentially (one class per cycle) to produce the winning class index.
//  The index is offered on a valid/ready handshake. Scores stay readable by
//  index through a registered readout port.
// PARAMETERS
//  DATA_WIDTH   5    signed score width (fix5 default)
//  NUM_CLASSES  10   number of class scores; must be >= 2
//  IDX_W        $clog2(NUM_CLASSES)   index width (derived, do not override)
// PORTS
//  clk           in   1                   single clock, rising edge
//  rst           in   1                   synchronous reset, active-low
//  clear         in   1                   soft clear: to IDLE, bank zeroed
//  core_done     in   1                   done level from inference core
//  scores        in   NUM_CLASSES*DATA_WIDTH  packed signed scores, class k at [k*DW +: DW]
//  busy          out  1                   high in SCAN or DONE
//  result_valid  out  1                   class_idx/best_score valid
//  result_ready  in   1                   consumer accepts result
//  class_idx     out  IDX_W               argmax index
//  best_score    out  DATA_WIDTH          score at class_idx
//  rd_idx        in   IDX_W               readout select
//  rd_data       out  DATA_WIDTH          registered score[rd_idx]
// BEHAVIOUR
//  - Reset (rst=0 at edge): state IDLE; bank, class_idx, best_score, rd_data,
//    result_valid, busy all 0; core_done edge detector cleared to 0.
//  - Capture: rising edge of core_done (core_done & ~done_q) seen in IDLE
//    loads all scores into the bank; best<=score[0], idx<=0, scan ptr<=1; -> SCAN.
//  - SCAN: each cycle compares bank[ptr] > best (signed, strict). If true,
//    best/idx update. Ties keep the lower index. After ptr==NUM_CLASSES-1 -> DONE.
//  - Latency: result_valid rises NUM_CLASSES-1 cycles after the capture edge
//    (9 cycles at default).
//  - DONE: result_valid=1; class_idx/best_score stable until accepted.
//    valid&ready at an edge -> IDLE, result_valid=0 next cycle. valid does not
//    depend on ready; ready while not valid is ignored.
//  - A core_done rising edge outside IDLE is dropped; the bank is not overwritten.
//    A level held high across the return to IDLE does not retrigger.
//  - clear: same effect as reset except the edge detector keeps tracking.
//    clear has priority over capture and over handshake in the same cycle.
//  - Readout: rd_data <= bank[rd_idx] each cycle (1-cycle latency). If
//    rd_idx >= NUM_CLASSES, bank[0] is returned. Readout works in any state.
//  - Reset or clear mid-SCAN aborts the scan; no partial result is presented.
// CONFIGURATION
//  - ARGMAX_MARGIN_EN defined: also tracks the second-best score during SCAN.
//    Adds output margin [DATA_WIDTH:0] = best - second (signed, full width,
//    no saturation), valid with result_valid. Reset value is 0. Ties give margin 0.
//  - ARGMAX_MARGIN_EN undefined: no second-best register and no margin port.
//    Timing and all other ports are identical.
// STRUCTURE
//  - dnn_pkg: argmax_state_t enum {IDLE, SCAN, DONE}; function idx_w(n);
//    typedef fix5_t (signed [4:0]).
//  - One sub-module: dnn_score_bank (capture register array + registered
//    readout mux with the out-of-range->0 rule). The FSM and comparator stay
//    in the top.
// TESTING
//  1 scores={-3,7,2,15,0,-16,4,1,9,5} (class0..9), core_done 0->1 ->
//    valid after 9 cycles, class_idx=3, best_score=15.
//  2 all scores=-16 -> class_idx=0 (tie keeps lowest), best_score=-16;
//    with ARGMAX_MARGIN_EN, margin=0.
//  3 class2=11, class7=11, class4=6 (rest 0) -> class_idx=2;
//    margin option: margin=0. Change class7 to 8 -> margin=3.
//  4 result_ready low for 20 cycles: valid and class_idx held. Second core_done
//    edge during the hold is ignored. Then ready=1 -> valid falls next cycle;
//    rd_idx=3 -> rd_data=15 one cycle later. rd_idx=12 -> rd_data=bank[0].
//  5 rst=0 at scan cycle 4 -> next cycle all outputs 0, state IDLE. Capture
//    again -> correct result after 9 cycles.
//  6 clear and result_ready both high in DONE -> IDLE, bank zeroed, rd_data=0.
//    core_done held high -> no new capture until it goes low then high.

Source files
------------

// File: rtl/dnn_pkg.sv
// Shared types and helpers for the DNN result stage.
// State encoding for the argmax FSM, fix5 score type, index-width helper.
package dnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

  typedef logic signed [4:0] fix5_t;

  // Width needed to address n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dnn_score_bank.sv
// Score capture array with a scan read port and a registered readout port.
// Readout latency 1 cycle, no backpressure; out-of-range readout returns entry 0.
module dnn_score_bank
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH  = 5,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = idx_w(NUM_CLASSES)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                load,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0]   scores,
  input  logic [IDX_W-1:0]                    scan_idx,
  output logic signed [DATA_WIDTH-1:0]        scan_data,
  input  logic [IDX_W-1:0]                    rd_idx,
  output logic signed [DATA_WIDTH-1:0]        rd_data
);

  localparam logic [IDX_W:0] NUM_C = (IDX_W+1)'(NUM_CLASSES);

  logic signed [DATA_WIDTH-1:0] bank [NUM_CLASSES];
  logic                         rd_ok;
  logic                         scan_ok;

  assign rd_ok   = {1'b0, rd_idx} < NUM_C;
  assign scan_ok = {1'b0, scan_idx} < NUM_C;

  // Scan port is combinational so the comparator sees the entry in the same cycle.
  assign scan_data = scan_ok ? bank[scan_idx] : bank[0];

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        bank[k] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (load) begin
        for (int k = 0; k < NUM_CLASSES; k++) begin
          bank[k] <= scores[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      rd_data <= rd_ok ? bank[rd_idx] : bank[0];
    end
  end

endmodule

// File: rtl/dnn_result_argmax.sv
// Captures class scores on core_done rising edge, scans one class per cycle for the argmax.
// Result after NUM_CLASSES-1 cycles, held until result_ready; optional margin under ARGMAX_MARGIN_EN.
module dnn_result_argmax
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH  = 5,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = idx_w(NUM_CLASSES)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                core_done,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0]   scores,
  output logic                                busy,
  output logic                                result_valid,
  input  logic                                result_ready,
  output logic [IDX_W-1:0]                    class_idx,
  output logic signed [DATA_WIDTH-1:0]        best_score,
`ifdef ARGMAX_MARGIN_EN
  output logic signed [DATA_WIDTH:0]          margin,
`endif
  input  logic [IDX_W-1:0]                    rd_idx,
  output logic signed [DATA_WIDTH-1:0]        rd_data
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

  argmax_state_t                state;
  argmax_state_t                state_nxt;
  logic                         done_q;
  logic                         done_rise;
  logic                         capture;
  logic [IDX_W-1:0]             ptr;
  logic signed [DATA_WIDTH-1:0] best;
  logic [IDX_W-1:0]             idx;
  logic signed [DATA_WIDTH-1:0] scan_data;

  assign done_rise = core_done & ~done_q;

  dnn_score_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_CLASSES (NUM_CLASSES),
    .IDX_W       (IDX_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (capture),
    .scores    (scores),
    .scan_idx  (ptr),
    .scan_data (scan_data),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (done_rise) begin
          capture   = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (ptr == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Clear wins over capture and over the result handshake.
    if (clear) begin
      state_nxt = IDLE;
      capture   = 1'b0;
    end
  end

  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign class_idx    = idx;
  assign best_score   = best;

  // Edge detector keeps tracking through clear so a held level cannot retrigger.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= core_done;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      ptr  <= '0;
      best <= '0;
      idx  <= '0;
    end else if (capture) begin
      best <= scores[0 +: DATA_WIDTH];
      idx  <= '0;
      ptr  <= IDX_W'(1);
    end else if (state == SCAN) begin
      // Strict compare: ties leave the lower index in place.
      if (scan_data > best) begin
        best <= scan_data;
        idx  <= ptr;
      end
      ptr <= ptr + IDX_W'(1);
    end
  end

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] second;

  // Starting second at the most negative value is exact: any real runner-up is >= it.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      second <= '0;
    end else if (capture) begin
      second <= SCORE_MIN;
    end else if (state == SCAN) begin
      if (scan_data > best) begin
        second <= best;
      end else if (scan_data > second) begin
        second <= scan_data;
      end
    end
  end

  assign margin = {best[DATA_WIDTH-1], best} - {second[DATA_WIDTH-1], second};
`endif

endmodule
